// File: rtl/prim_rr_arb_pkg.sv
// Shared types for the round-robin arbiter with one-hot grant integrity check.
package prim_rr_arb_pkg;

  localparam int unsigned ArbStateWidth = 3;

  // Sparse state encodings, pairwise Hamming distance 2, so that a single
  // upset of the state register lands on an illegal code and is caught.
  typedef enum logic [ArbStateWidth-1:0] {
    IDLE  = 3'b011,
    GRANT = 3'b101,
    ERROR = 3'b110
  } arb_state_e;

endpackage : prim_rr_arb_pkg

// File: rtl/prim_onehot_check.sv
// Combinational integrity checker for a one-hot vector with its binary
// address and an enable qualifier. err_o rises on any inconsistency.
module prim_onehot_check #(
  parameter int unsigned OneHotWidth = 4,
  parameter int unsigned AddrWidth   = 2,
  parameter bit          AddrCheck   = 1'b1,
  parameter bit          EnableCheck = 1'b1,
  parameter bit          StrictCheck = 1'b1
) (
  input  logic [OneHotWidth-1:0] oh_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   en_i,
  output logic                   err_o
);

  logic [OneHotWidth-1:0] addr_oh;
  logic                   any_hot;
  logic                   multi_hot;
  logic                   oh_err;
  logic                   enable_err;
  logic                   addr_err;

  // Decode the address into the one-hot vector it should correspond to.
  // Out-of-range addresses decode to all-zero and therefore never match.
  for (genvar gi = 0; gi < OneHotWidth; gi++) begin : gen_addr_dec
    assign addr_oh[gi] = (addr_i == AddrWidth'(gi));
  end

  assign any_hot   = |oh_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(oh_i & (oh_i - OneHotWidth'(1)));

  // More than one hot bit is always a fault, regardless of enable.
  assign oh_err     = multi_hot;
  // Hot bits without enable are a fault; strict mode also rejects an
  // enabled vector that carries no hot bit at all.
  assign enable_err = EnableCheck &&
                      ((!en_i && any_hot) || (StrictCheck && en_i && !any_hot));
  // An enabled, non-empty vector must match the decoded address exactly.
  assign addr_err   = AddrCheck && en_i && any_hot && (oh_i != addr_oh);

  assign err_o = oh_err | enable_err | addr_err;

endmodule : prim_onehot_check

// File: rtl/prim_rr_arb_oh_checked.sv
// Round-robin arbiter issuing a registered one-hot grant and binary index
// under valid/ready. The live grant is integrity checked every cycle; any
// fault or illegal state drives a terminal ERROR state with sticky err_o.
module prim_rr_arb_oh_checked
  import prim_rr_arb_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                err_o
);

  arb_state_e          state_q, state_d;
  logic [NumReq-1:0]   gnt_q, gnt_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic                err_q, err_d;
  logic                chk_err;
  logic [IdxWidth-1:0] pick_idx;

  // Round-robin pick: lowest requester at or above ptr; if none, wrap to the
  // lowest requester overall. Caller only uses the result when req is non-zero.
  function automatic logic [IdxWidth-1:0] rr_pick(input logic [NumReq-1:0]   req,
                                                  input logic [IdxWidth-1:0] ptr);
    logic [NumReq-1:0]   masked;
    logic [IdxWidth-1:0] idx_m;
    logic [IdxWidth-1:0] idx_u;
    masked = '0;
    idx_m  = '0;
    idx_u  = '0;
    for (int i = 0; i < NumReq; i++) begin
      masked[i] = req[i] && (IdxWidth'(i) >= ptr);
    end
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (masked[i]) idx_m = IdxWidth'(i);
      if (req[i])    idx_u = IdxWidth'(i);
    end
    return (|masked) ? idx_m : idx_u;
  endfunction

  assign pick_idx = rr_pick(req_i, ptr_q);

  assign valid_o = (state_q == GRANT);
  assign gnt_o   = gnt_q;
  assign idx_o   = idx_q;
  assign err_o   = err_q;

  prim_onehot_check #(
    .OneHotWidth (NumReq),
    .AddrWidth   (IdxWidth),
    .AddrCheck   (1'b1),
    .EnableCheck (1'b1),
    .StrictCheck (1'b1)
  ) u_onehot_check (
    .oh_i   (gnt_q),
    .addr_i (idx_q),
    .en_i   (valid_o),
    .err_o  (chk_err)
  );

  // Next-state and next-grant logic; a checker hit in any live state wins.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (chk_err) begin
          state_d = ERROR;
          err_d   = 1'b1;
          gnt_d   = '0;
          idx_d   = '0;
        end else if (|req_i) begin
          state_d = GRANT;
          gnt_d   = NumReq'(1) << pick_idx;
          idx_d   = pick_idx;
        end
      end
      GRANT: begin
        if (chk_err) begin
          state_d = ERROR;
          err_d   = 1'b1;
          gnt_d   = '0;
          idx_d   = '0;
        end else if (ready_i) begin
          state_d = IDLE;
          ptr_d   = (idx_q == IdxWidth'(NumReq - 1)) ? '0 : idx_q + IdxWidth'(1);
          gnt_d   = '0;
          idx_d   = '0;
        end
      end
      ERROR: begin
        err_d = 1'b1;
        gnt_d = '0;
        idx_d = '0;
      end
      default: begin
        state_d = ERROR;
        err_d   = 1'b1;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and grant registers; reset drops any grant in flight immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

`ifndef SYNTHESIS
  // Fault-free operating properties; suppressed while the checker is
  // reporting, since that is exactly when they are expected to break.
  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i || chk_err)
    $onehot0(gnt_o));
  a_valid_onehot: assert property (@(posedge clk_i) disable iff (rst_i || chk_err)
    valid_o |-> $onehot(gnt_o));
  a_gnt_stable: assert property (@(posedge clk_i) disable iff (rst_i || chk_err)
    (valid_o && !ready_i) |=> ($stable(gnt_o) && $stable(idx_o) && valid_o));
  a_err_sticky: assert property (@(posedge clk_i) disable iff (rst_i)
    err_o |=> err_o);
  a_ptr_range: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(ptr_q) < int'(NumReq));
`endif

endmodule : prim_rr_arb_oh_checked

// File: tb/tb_prim_rr_arb_oh_checked.sv
// Self-checking bench for prim_rr_arb_oh_checked (NumReq=4, IdxWidth=2).
module tb_prim_rr_arb_oh_checked;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       ready = 1'b0;
  logic       valid;
  logic [3:0] gnt;
  logic [1:0] idx;
  logic       err;

  int total = 0;
  int bad   = 0;

  // Reference model: "a grant is outstanding for requester m_idx", plus the
  // round-robin start position and a sticky fault flag.
  bit m_busy = 1'b0;
  bit m_err  = 1'b0;
  int m_idx  = 0;
  int m_ptr  = 0;

  prim_rr_arb_oh_checked #(.NumReq(4), .IdxWidth(2)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .ready_i (ready),
    .valid_o (valid),
    .gnt_o   (gnt),
    .idx_o   (idx),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  // Search starting at p and walking upward modulo N.
  function automatic int ref_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic exp_valid();
    return m_busy && !m_err;
  endfunction

  function automatic logic [3:0] exp_gnt();
    logic [3:0] one;
    one = 4'b0001;
    return exp_valid() ? (one << m_idx) : 4'b0000;
  endfunction

  function automatic logic [1:0] exp_idx();
    return exp_valid() ? 2'(m_idx) : 2'd0;
  endfunction

  // Advance the model by one clock from the current inputs, then the DUT.
  task automatic tick();
    if (!m_err) begin
      if (!m_busy) begin
        if (req != 4'b0000) begin
          m_idx  = ref_pick(req, m_ptr);
          m_busy = 1'b1;
        end
      end else if (ready) begin
        m_ptr  = (m_idx + 1) % N;
        m_busy = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_ptr  = 0;
    m_idx  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req   = 4'b0000;
    ready = 1'b0;
    rst   = 1'b1;
    #2;
    total++;
    if (valid !== 1'b0 || gnt !== 4'b0000 || idx !== 2'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: valid=%b gnt=%b idx=%0d err=%b want 0 0000 0 0",
               valid, gnt, idx, err);
    end
    do_reset();
    for (int c = 0; c < 100; c++) begin
      req   = 4'b0000;
      ready = 1'($urandom_range(0, 1));
      tick();
      total++;
      if (valid !== 1'b0 || gnt !== 4'b0000 || err !== 1'b0) begin
        bad++;
        $display("FAIL idle_no_req cyc%0d: valid=%b gnt=%b err=%b want 0 0000 0",
                 c, valid, gnt, err);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_fairness();
    int seq[$];
    int want[5];
    want = '{0, 1, 2, 3, 0};
    do_reset();
    req   = 4'b1111;
    ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (valid !== exp_valid() || gnt !== exp_gnt() || idx !== exp_idx()) begin
        bad++;
        $display("FAIL fair cyc%0d: valid=%b gnt=%b idx=%0d want %b %b %0d",
                 c, valid, gnt, idx, exp_valid(), exp_gnt(), exp_idx());
      end
      if (valid === 1'b1) seq.push_back(int'(idx));
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (seq.size() <= k) begin
        bad++;
        $display("FAIL fair_seq[%0d]: missing grant, want idx %0d", k, want[k]);
      end else if (seq[k] != want[k]) begin
        bad++;
        $display("FAIL fair_seq[%0d]: idx=%0d want %0d", k, seq[k], want[k]);
      end
    end
    $display("test_fairness done: %0d grants in 10 cycles", seq.size());
  endtask

  task automatic test_wrap();
    do_reset();
    ready = 1'b1;
    req   = 4'b0010;
    tick();                 // grant 1
    tick();                 // accepted, pointer now 2
    req = 4'b0011;
    tick();
    total++;
    if (valid !== 1'b1 || idx !== 2'd0 || gnt !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_first: valid=%b idx=%0d gnt=%b want 1 0 0001", valid, idx, gnt);
    end
    tick();                 // accepted, pointer now 1
    tick();
    total++;
    if (valid !== 1'b1 || idx !== 2'd1 || gnt !== 4'b0010) begin
      bad++;
      $display("FAIL wrap_second: valid=%b idx=%0d gnt=%b want 1 1 0010", valid, idx, gnt);
    end
    $display("test_wrap done");
  endtask

  task automatic test_hold();
    do_reset();
    req   = 4'b0100;
    ready = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      if (c == 3) req = 4'b0000;
      tick();
      total++;
      if (valid !== 1'b1 || gnt !== 4'b0100 || idx !== 2'd2) begin
        bad++;
        $display("FAIL hold cyc%0d: valid=%b gnt=%b idx=%0d want 1 0100 2",
                 c, valid, gnt, idx);
      end
    end
    ready = 1'b1;
    tick();
    total++;
    if (valid !== 1'b0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL hold_accept: valid=%b gnt=%b want 0 0000", valid, gnt);
    end
    req   = 4'b1111;
    ready = 1'b0;
    tick();
    total++;
    if (valid !== 1'b1 || idx !== 2'd3) begin
      bad++;
      $display("FAIL hold_next_ptr: valid=%b idx=%0d want 1 3", valid, idx);
    end
    $display("test_hold done");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req   = 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      tick();
      total++;
      if (valid !== exp_valid() || gnt !== exp_gnt() || idx !== exp_idx() || err !== 1'b0) begin
        bad++;
        $display("FAIL random cyc%0d: valid=%b gnt=%b idx=%0d err=%b want %b %b %0d 0",
                 c, valid, gnt, idx, err, exp_valid(), exp_gnt(), exp_idx());
      end
    end
    $display("test_random done");
  endtask

  task automatic test_fault();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      ready = 1'b0;
      req   = (v == 0) ? 4'b0001 : 4'b0100;
      tick();
      total++;
      if (valid !== 1'b1 || err !== 1'b0) begin
        bad++;
        $display("FAIL fault%0d_pre: valid=%b err=%b want 1 0", v, valid, err);
      end
      if (v == 0) force dut.gnt_q = 4'b0110;
      else        force dut.idx_q = 2'd3;
      @(posedge clk);
      #1;
      if (v == 0) release dut.gnt_q;
      else        release dut.idx_q;
      m_err  = 1'b1;
      m_busy = 1'b0;
      total++;
      if (err !== 1'b1 || valid !== 1'b0) begin
        bad++;
        $display("FAIL fault%0d_detect: err=%b valid=%b want 1 0", v, err, valid);
      end
      for (int c = 0; c < 6; c++) begin
        req   = 4'($urandom_range(0, 15));
        ready = 1'($urandom_range(0, 1));
        tick();
        total++;
        if (err !== 1'b1 || valid !== 1'b0 || gnt !== 4'b0000 || idx !== 2'd0) begin
          bad++;
          $display("FAIL fault%0d_sticky cyc%0d: err=%b valid=%b gnt=%b idx=%0d want 1 0 0000 0",
                   v, c, err, valid, gnt, idx);
        end
      end
      req   = 4'b0000;
      ready = 1'b0;
      do_reset();
      total++;
      if (err !== 1'b0 || valid !== 1'b0) begin
        bad++;
        $display("FAIL fault%0d_clear: err=%b valid=%b want 0 0", v, err, valid);
      end
    end
    $display("test_fault done");
  endtask

  task automatic test_async_reset();
    do_reset();
    req   = 4'b0010;
    ready = 1'b0;
    tick();
    total++;
    if (valid !== 1'b1 || idx !== 2'd1) begin
      bad++;
      $display("FAIL async_pre: valid=%b idx=%0d want 1 1", valid, idx);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (valid !== 1'b0 || gnt !== 4'b0000 || idx !== 2'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: valid=%b gnt=%b idx=%0d err=%b want 0 0000 0 0",
               valid, gnt, idx, err);
    end
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_ptr  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1000;
    tick();
    total++;
    if (valid !== 1'b1 || idx !== 2'd3 || gnt !== 4'b1000) begin
      bad++;
      $display("FAIL async_after: valid=%b idx=%0d gnt=%b want 1 3 1000", valid, idx, gnt);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_wrap();
    test_hold();
    test_random();
    test_fault();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prim_rr_arb_oh_checked
